// File: rtl/fx3_bus_out_response_if.sv
// Bundle of the master-status, FIFO read-side and FX3 outbound signals
// used by fx3_bus_out_response.
interface fx3_bus_out_response_if;
  logic        i_out_path_enable;
  logic        o_out_path_busy;
  logic        o_out_path_finished;
  logic [7:0]  i_status;
  logic [7:0]  i_flag;
  logic [31:0] i_rw_count;
  logic [31:0] i_address;
  logic        i_send_data;
  logic        i_out_ready;
  logic        o_out_activate;
  logic [23:0] i_out_packet_size;
  logic [31:0] i_out_data;
  logic        o_out_strobe;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        i_fx3_ready;

  modport master (
    output i_out_path_enable, i_status, i_flag, i_rw_count, i_address,
           i_send_data, i_out_ready, i_out_packet_size, i_out_data, i_fx3_ready,
    input  o_out_path_busy, o_out_path_finished, o_out_activate, o_out_strobe,
           o_data, o_data_valid
  );

  modport slave (
    input  i_out_path_enable, i_status, i_flag, i_rw_count, i_address,
           i_send_data, i_out_ready, i_out_packet_size, i_out_data, i_fx3_ready,
    output o_out_path_busy, o_out_path_finished, o_out_activate, o_out_strobe,
           o_data, o_data_valid
  );
endinterface

// File: rtl/fx3_bus_out_response.sv
// FX3 outbound response serialiser: four-word header (id/flag/status, count,
// address, checksum) followed by optional payload drained from the ping-pong FIFO.
module fx3_bus_out_response #(
  parameter logic [15:0] ID_WORD = 16'hCD15
) (
  input logic                   clk,
  input logic                   rst,
  fx3_bus_out_response_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_ID,
    S_SEND_COUNT,
    S_SEND_ADDRESS,
    S_SEND_CHECKSUM,
    S_SEND_DATA,
    S_FINISHED
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  flag_q, flag_d;
  logic [31:0] count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic        send_data_q, send_data_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        act_q, act_d;
  logic [31:0] sent_q, sent_d;
  logic [23:0] pkt_q, pkt_d;
  logic        strobe;
  logic        accept;
  logic        can_load;
  logic [31:0] word0;

  assign accept   = valid_q & bus.i_fx3_ready;
  assign can_load = ~valid_q | accept;
  assign word0    = {ID_WORD, flag_q, status_q};

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    flag_d      = flag_q;
    count_d     = count_q;
    addr_d      = addr_q;
    send_data_d = send_data_q;
    data_d      = data_q;
    valid_d     = valid_q;
    act_d       = act_q;
    sent_d      = sent_q;
    pkt_d       = pkt_q;
    strobe      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_out_path_enable) begin
          status_d    = bus.i_status;
          flag_d      = bus.i_flag;
          count_d     = bus.i_rw_count;
          addr_d      = bus.i_address;
          send_data_d = bus.i_send_data;
          sent_d      = '0;
          pkt_d       = '0;
          act_d       = 1'b0;
          data_d      = {ID_WORD, bus.i_flag, bus.i_status};
          valid_d     = 1'b1;
          state_d     = S_SEND_ID;
        end
      end
      S_SEND_ID: begin
        if (accept) begin
          data_d  = count_q;
          state_d = S_SEND_COUNT;
        end
      end
      S_SEND_COUNT: begin
        if (accept) begin
          data_d  = addr_q;
          state_d = S_SEND_ADDRESS;
        end
      end
      S_SEND_ADDRESS: begin
        if (accept) begin
          data_d  = word0 + count_q + addr_q;
          state_d = S_SEND_CHECKSUM;
        end
      end
      S_SEND_CHECKSUM: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = (send_data_q && (count_q != '0)) ? S_SEND_DATA : S_FINISHED;
        end
      end
      S_SEND_DATA: begin
        // Once every word is loaded, activate stays claimed until the last word leaves.
        if (sent_q == count_q) begin
          if (can_load) begin
            valid_d = 1'b0;
            act_d   = 1'b0;
            state_d = S_FINISHED;
          end
        end else begin
          if (accept) valid_d = 1'b0;
          if (!act_q) begin
            if (bus.i_out_ready) begin
              act_d = 1'b1;
              pkt_d = '0;
            end
          end else if (pkt_q >= bus.i_out_packet_size) begin
            act_d = 1'b0;
          end else if (can_load) begin
            data_d  = bus.i_out_data;
            valid_d = 1'b1;
            strobe  = 1'b1;
            sent_d  = sent_q + 32'd1;
            pkt_d   = pkt_q + 24'd1;
          end
        end
      end
      S_FINISHED: begin
        if (!bus.i_out_path_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      status_q    <= '0;
      flag_q      <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      send_data_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      act_q       <= 1'b0;
      sent_q      <= '0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      flag_q      <= flag_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      send_data_q <= send_data_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      act_q       <= act_d;
      sent_q      <= sent_d;
      pkt_q       <= pkt_d;
    end
  end

  assign bus.o_data              = data_q;
  assign bus.o_data_valid        = valid_q;
  assign bus.o_out_activate      = act_q;
  assign bus.o_out_strobe        = strobe;
  assign bus.o_out_path_busy     = (state_q != S_IDLE) && (state_q != S_FINISHED);
  assign bus.o_out_path_finished = (state_q == S_FINISHED);

endmodule

// File: tb/tb_fx3_bus_out_response.sv
// Directed bench for fx3_bus_out_response: FIFO read-side model plus a
// scoreboard of expected outbound words checked as FX3 accepts them.
module tb_fx3_bus_out_response;
  logic clk;
  logic rst;

  fx3_bus_out_response_if bus();

  fx3_bus_out_response #(.ID_WORD(16'hCD15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          n_acc, first_acc, last_acc, cyc;
  logic        act_at_acc;
  bit          bp_mode;
  int          bp_ph;

  // FIFO read-side model
  logic [31:0] fifo_mem[16];
  int          pk_size[4];
  int          pk_base[4];
  int          n_pk;
  int          pk_idx, rd_ptr, strobes, claims;
  logic        act_prev;
  logic        model_clr;

  always_comb begin
    bus.i_out_ready       = (pk_idx < n_pk) && !bus.o_out_activate;
    bus.i_out_packet_size = (pk_idx < n_pk) ? 24'(pk_size[pk_idx]) : 24'd0;
    bus.i_out_data        = 32'hDEAD_0000;
    if (pk_idx < n_pk && rd_ptr < pk_size[pk_idx])
      bus.i_out_data = fifo_mem[pk_base[pk_idx] + rd_ptr];
  end

  always @(posedge clk) begin
    if (model_clr || !bus.o_out_activate) rd_ptr <= 0;
    else if (bus.o_out_strobe)            rd_ptr <= rd_ptr + 1;
    if (bus.o_out_strobe) strobes <= strobes + 1;
  end

  always @(negedge clk) begin
    if (model_clr) begin
      pk_idx   <= 0;
      act_prev <= 1'b0;
    end else begin
      act_prev <= bus.o_out_activate;
      if (!act_prev && bus.o_out_activate) claims <= claims + 1;
      if (act_prev && !bus.o_out_activate) pk_idx <= pk_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    bit          hold_pend;
    logic [31:0] hold_data;
    bit          in_pkt;
    hold_pend = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (bus.o_out_strobe) begin
          in_pkt = (pk_idx < n_pk) ? (rd_ptr < pk_size[pk_idx]) : 1'b0;
          check("strobe_needs_activate", 32'(bus.o_out_activate), 32'd1);
          check("strobe_within_packet", 32'(in_pkt), 32'd1);
        end
        if (hold_pend) begin
          check("hold_valid", 32'(bus.o_data_valid), 32'd1);
          check("hold_data", bus.o_data, hold_data);
        end
        if (bus.o_data_valid && bus.i_fx3_ready) begin
          if (exp_q.size() == 0) check("unexpected_word", bus.o_data, 32'hXXXX_XXXX);
          else                   check("word", bus.o_data, exp_q.pop_front());
          n_acc++;
          last_acc   = cyc;
          act_at_acc = bus.o_out_activate;
          if (first_acc < 0) first_acc = cyc;
        end
        hold_pend = bus.o_data_valid && !bus.i_fx3_ready;
        hold_data = bus.o_data;
      end else begin
        hold_pend = 1'b0;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      bus.i_fx3_ready = bp_mode ? (bp_ph == 0) : 1'b1;
      bp_ph = (bp_ph + 1) % 3;
    end
  endtask

  task automatic set_pkts(input int n, input int s0, input int s1, input logic [31:0] base);
    n_pk       = 0;
    pk_size[0] = s0;
    pk_size[1] = s1;
    pk_base[0] = 0;
    pk_base[1] = s0;
    for (int i = 0; i < 16; i++) fifo_mem[i] = base + 32'(i);
    model_clr = 1'b1;
    step();
    n_pk      = n;
    model_clr = 1'b0;
  endtask

  task automatic run_resp(input logic [7:0] st, input logic [7:0] fl, input logic [31:0] cnt,
                          input logic [31:0] ad, input logic sd, input int exp_str,
                          input int exp_clm, input int exp_span, input bit chk_act);
    logic [31:0] w0;
    int          s0, c0, rem;
    w0 = {16'hCD15, fl, st};
    exp_q.push_back(w0);
    exp_q.push_back(cnt);
    exp_q.push_back(ad);
    exp_q.push_back(w0 + cnt + ad);
    if (sd) begin
      rem = int'(cnt);
      for (int p = 0; p < n_pk; p++)
        for (int j = 0; j < pk_size[p]; j++)
          if (rem > 0) begin
            exp_q.push_back(fifo_mem[pk_base[p] + j]);
            rem--;
          end
    end
    s0 = strobes;
    c0 = claims;
    n_acc = 0;
    first_acc = -1;
    bus.i_status = st;
    bus.i_flag = fl;
    bus.i_rw_count = cnt;
    bus.i_address = ad;
    bus.i_send_data = sd;
    bus.i_out_path_enable = 1'b1;
    step();
    check("busy_at_start", 32'(bus.o_out_path_busy), 32'd1);
    check("header_valid_at_start", 32'(bus.o_data_valid), 32'd1);
    for (int i = 0; i < 300 && !bus.o_out_path_finished; i++) step();
    check("finished", 32'(bus.o_out_path_finished), 32'd1);
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("accepted", 32'(n_acc), 32'd4 + (sd ? cnt : 32'd0));
    check("strobes", 32'(strobes - s0), 32'(exp_str));
    check("claims", 32'(claims - c0), 32'(exp_clm));
    check("activate_after", 32'(bus.o_out_activate), 32'd0);
    if (exp_span >= 0) check("span", 32'(last_acc - first_acc), 32'(exp_span));
    if (chk_act) check("activate_at_last_accept", 32'(act_at_acc), 32'd1);
    repeat (3) step();
    check("no_second_response", 32'(bus.o_data_valid), 32'd0);
    check("still_finished", 32'(bus.o_out_path_finished), 32'd1);
    bus.i_out_path_enable = 1'b0;
    step();
    check("idle_finished_low", 32'(bus.o_out_path_finished), 32'd0);
    check("idle_busy_low", 32'(bus.o_out_path_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    model_clr = 1'b1;
    n_pk = 0;
    bp_mode = 1'b0;
    bp_ph = 0;
    cyc = 0;
    first_acc = -1;
    bus.i_out_path_enable = 1'b0;
    bus.i_status = '0;
    bus.i_flag = '0;
    bus.i_rw_count = '0;
    bus.i_address = '0;
    bus.i_send_data = 1'b0;
    bus.i_fx3_ready = 1'b1;
    fork
      monitor();
      ready_driver();
      begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
      end
    join_none
    step();
    step();
    check("rst_data", bus.o_data, 32'd0);
    check("rst_valid", 32'(bus.o_data_valid), 32'd0);
    check("rst_activate", 32'(bus.o_out_activate), 32'd0);
    check("rst_strobe", 32'(bus.o_out_strobe), 32'd0);
    check("rst_busy", 32'(bus.o_out_path_busy), 32'd0);
    check("rst_finished", 32'(bus.o_out_path_finished), 32'd0);
    rst = 1'b1;
    model_clr = 1'b0;
    step();

    // status-only response
    set_pkts(0, 0, 0, 32'h0);
    run_resp(8'h01, 8'h00, 32'd0, 32'h10, 1'b0, 0, 0, 3, 1'b0);

    // read response, single packet, back-to-back payload
    set_pkts(1, 4, 0, 32'hA0A0_0000);
    run_resp(8'h00, 8'h80, 32'd4, 32'h2000, 1'b1, 4, 1, 9, 1'b1);

    // same under backpressure
    bp_mode = 1'b1;
    set_pkts(1, 4, 0, 32'hA1A1_0000);
    run_resp(8'h02, 8'h81, 32'd4, 32'h3000, 1'b1, 4, 1, -1, 1'b1);
    bp_mode = 1'b0;

    // payload split across two packets
    set_pkts(2, 4, 2, 32'hB0B0_0000);
    run_resp(8'h03, 8'h82, 32'd6, 32'h4000, 1'b1, 6, 2, -1, 1'b0);
    check("split_packets_consumed", 32'(pk_idx), 32'd2);

    // count shorter than packet
    set_pkts(1, 4, 0, 32'hC0C0_0000);
    run_resp(8'h04, 8'h83, 32'd3, 32'h5000, 1'b1, 3, 1, -1, 1'b1);
    check("early_release_packet_done", 32'(pk_idx), 32'd1);

    // reset mid-payload
    set_pkts(1, 4, 0, 32'hD0D0_0000);
    exp_q.push_back({16'hCD15, 8'h84, 8'h05});
    exp_q.push_back(32'd4);
    exp_q.push_back(32'h6000);
    exp_q.push_back({16'hCD15, 8'h84, 8'h05} + 32'd4 + 32'h6000);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hD0D0_0000 + 32'(i));
    n_acc = 0;
    bus.i_status = 8'h05;
    bus.i_flag = 8'h84;
    bus.i_rw_count = 32'd4;
    bus.i_address = 32'h6000;
    bus.i_send_data = 1'b1;
    bus.i_out_path_enable = 1'b1;
    for (int i = 0; i < 300 && n_acc < 6; i++) step();
    check("mid_payload_reached", 32'(n_acc), 32'd6);
    rst = 1'b0;
    #1;
    check("mrst_data", bus.o_data, 32'd0);
    check("mrst_valid", 32'(bus.o_data_valid), 32'd0);
    check("mrst_activate", 32'(bus.o_out_activate), 32'd0);
    check("mrst_strobe", 32'(bus.o_out_strobe), 32'd0);
    check("mrst_busy", 32'(bus.o_out_path_busy), 32'd0);
    check("mrst_finished", 32'(bus.o_out_path_finished), 32'd0);
    exp_q.delete();
    bus.i_out_path_enable = 1'b0;
    step();
    rst = 1'b1;
    step();
    set_pkts(0, 0, 0, 32'h0);
    run_resp(8'h5A, 8'h3C, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 0, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fx3_bus_out_response.md
Name: fx3_bus_out_response

Overview:
- Host-bound counterpart of the FX3 inbound command parser.
- Serialises a four-word response header onto the 32-bit FX3 outbound stream: ID/flag/status, count, address, checksum.
- When requested, then streams rw_count payload words drained from the master's ping-pong FIFO read side.
- Sits between the master (status + FIFO) and the FX3 GPIF write path.

Parameters:
ID_WORD, 16'hCD15, constant placed in bits [31:16] of header word 0.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
i_out_path_enable  in  1  request to send one response; held until o_out_path_finished
o_out_path_busy  out  1  high while state is neither IDLE nor FINISHED
o_out_path_finished  out  1  high while state is FINISHED
i_status  in  8  response status byte; latched at start
i_flag  in  8  response flag byte; latched at start
i_rw_count  in  32  payload word count; latched at start
i_address  in  32  response address; latched at start
i_send_data  in  1  1 = payload follows header; latched at start
i_out_ready  in  1  FIFO read side has a packet available
o_out_activate  out  1  FIFO read-side packet claim
i_out_packet_size  in  24  words in the claimed packet
i_out_data  in  32  current FIFO word (first-word-fall-through)
o_out_strobe  out  1  consume current FIFO word; next word is valid on the following cycle
o_data  out  32  outbound word to FX3
o_data_valid  out  1  o_data holds a word
i_fx3_ready  in  1  FX3 accepts the word when sampled high together with o_data_valid

Behaviour:
- Reset (rst low, any time, asynchronous):
  - State goes to IDLE.
  - o_data = 0, o_data_valid = 0, o_out_activate = 0, o_out_strobe = 0; busy and finished low.
  - Latched fields and all counters clear.
  - Any transfer in flight is abandoned; no partial word is held.
- States: IDLE, SEND_ID, SEND_COUNT, SEND_ADDRESS, SEND_CHECKSUM, SEND_DATA, FINISHED.
- IDLE, on i_out_path_enable = 1:
  - Latch i_status, i_flag, i_rw_count, i_address, i_send_data.
  - Load o_data = {ID_WORD, i_flag, i_status} and set o_data_valid.
  - Go to SEND_ID. Header word 0 is valid on the cycle after enable is sampled.
- Output register rule: o_data and o_data_valid may change only when o_data_valid = 0, or on the edge where o_data_valid & i_fx3_ready = 1 (accept). Otherwise o_data holds stable.
- On accept, each header state loads its successor word in the same edge, giving 1 word per cycle:
  - SEND_ID → SEND_COUNT, loads count.
  - SEND_COUNT → SEND_ADDRESS, loads address.
  - SEND_ADDRESS → SEND_CHECKSUM, loads checksum = (word0 + count + address) mod 2^32.
- Accept of the checksum word:
  - If send_data = 1 and count ≠ 0: go to SEND_DATA with o_data_valid = 0.
  - Otherwise: go to FINISHED with o_data_valid = 0.
- FIFO claim:
  - Only in SEND_DATA, and only while o_out_activate = 0 and i_out_ready = 1.
  - Set o_out_activate and clear the packet word counter.
  - Release when the packet counter reaches i_out_packet_size, or when all count words have been sent. Unread words in a released packet are discarded.
- SEND_DATA loading: when the output register may load, o_out_activate = 1, the packet counter < packet size, and sent words < count:
  - Load o_data = i_out_data and set o_data_valid.
  - Pulse o_out_strobe for 1 cycle.
  - Increment both counters.
  - Sustained rate is 1 word per cycle while FX3 is ready.
- Never strobe the same FIFO word twice; never strobe when o_out_activate = 0.
- SEND_DATA completion: when sent words = count and the final word has been accepted:
  - Drop o_out_activate.
  - Go to FINISHED.
- FINISHED: go to IDLE when i_out_path_enable = 0. Enable still high keeps the block in FINISHED; no second response is sent.
- Packet boundary mid-payload: release, then reclaim the next ready packet. Payload continues without header re-send.
- i_fx3_ready low: hold o_data and o_data_valid; no strobe, no counter change.
- Counters are 32-bit for payload and 24-bit for packet; no wrap is permitted within one response.

Test Plan:
- Status-only response: status=8'h01, flag=8'h00, count=0, address=32'h10, send_data=0, FX3 always ready → words CD150001, 00000000, 00000010, CD150011 on 4 consecutive cycles; then FINISHED, no strobes.
- Read response: send_data=1, count=4, one FIFO packet of size 4 holding A0..A3 → header then A0..A3 back-to-back, exactly 4 strobes, activate drops after A3 is accepted.
- Backpressure: same as previous, i_fx3_ready toggled 1,0,0,1,… → each word held stable while ready is 0; no duplicated or skipped words.
- Packet split: count=6, two FIFO packets of size 4 and 2 → 6 payload words in order, two activate periods; the 2 unread-slot condition never strobes.
- Early release: count=3, packet size 4 → 3 words sent, activate released, fourth word not strobed, FINISHED.
- Reset mid-payload: assert rst low after 2 payload words → all outputs 0 immediately; a new enable afterwards produces a fresh header.
